// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline. It handles boot, redirects,
// load-use stalls, fetch misses and memory freezes, and keeps two saturating performance counters.
module pipe_ctrl #(
  parameter logic [31:0] BOOT_PC = 32'h0000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       hz_stall,
  input  logic [31:0]      hz_pc_branch,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             imem_req,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    RWAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_r, state_nxt_s;
  logic [31:0] pend_pc_r, pend_pc_nxt_s;
  logic        stall_inc_s, flush_inc_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // State, pending redirect target and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= BOOT;
      pend_pc_r   <= 32'h0000_0000;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pend_pc_r <= pend_pc_nxt_s;
      if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // Next-state and control-output decode; enables default on, flushes default off.
  always_comb begin
    state_nxt_s   = state_r;
    pend_pc_nxt_s = pend_pc_r;
    flush_inc_s   = 1'b0;
    imem_req      = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    pc_target     = pend_pc_r;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;

    case (state_r)
      BOOT: begin
        pc_we        = 1'b1;
        pc_sel       = 1'b1;
        pc_target    = BOOT_PC;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        state_nxt_s  = RUN;
      end
      RUN: begin
        imem_req = 1'b1;
        if (dmem_busy) begin
          // Freeze: hazards are re-evaluated once MEM completes.
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (hz_stall[1]) begin
          pc_target   = hz_pc_branch;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc_s = 1'b1;
          if (imem_ready) begin
            pc_we  = 1'b1;
            pc_sel = 1'b1;
          end else begin
            pend_pc_nxt_s = hz_pc_branch;
            state_nxt_s   = RWAIT;
          end
        end else if (hz_stall[0]) begin
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
        end else begin
          pc_we = 1'b1;
        end
      end
      RWAIT: begin
        imem_req  = 1'b1;
        pc_target = pend_pc_r;
        if (dmem_busy) begin
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (imem_ready) begin
          // The word returned now is from the wrong path; drop it while loading the target.
          pc_we       = 1'b1;
          pc_sel      = 1'b1;
          if_id_flush = 1'b1;
          state_nxt_s = RUN;
        end else begin
          if_id_flush = 1'b1;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  assign stall_inc_s = ((state_r == RUN) || (state_r == RWAIT)) && !pc_we;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (CNT_W=4, BOOT_PC=32'h100) with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  hz_stall;
  logic [31:0] hz_pc_branch;
  logic        imem_ready;
  logic        dmem_busy;
  logic        imem_req, pc_we, pc_sel;
  logic [31:0] pc_target;
  logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [3:0]  stall_cnt, flush_cnt;

  int checks;
  int failures;

  pipe_ctrl #(.BOOT_PC(32'h0000_0100), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .hz_pc_branch(hz_pc_branch),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy), .imem_req(imem_req),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control vector: {imem_req, pc_we, pc_sel, en[if,id,ex,mem], flush[if,id,ex,mem]}
  localparam logic [10:0] C_BOOT   = 11'b011_0000_1111;
  localparam logic [10:0] C_NORM   = 11'b110_1111_0000;
  localparam logic [10:0] C_REDIR  = 11'b111_1111_1100;
  localparam logic [10:0] C_RMISS  = 11'b100_1111_1100;
  localparam logic [10:0] C_WAIT   = 11'b100_1111_1000;
  localparam logic [10:0] C_WDONE  = 11'b111_1111_1000;
  localparam logic [10:0] C_LDUSE  = 11'b100_0111_0100;
  localparam logic [10:0] C_FREEZE = 11'b100_0000_0000;

  function automatic logic [10:0] ctrl_vec();
    return {imem_req, pc_we, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before checking.
  task automatic drive(input logic [1:0] hz, input logic [31:0] br, input logic rdy, input logic busy);
    @(negedge clk);
    hz_stall     = hz;
    hz_pc_branch = br;
    imem_ready   = rdy;
    dmem_busy    = busy;
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] s, input logic [3:0] f);
    chk({tag, "_stall"}, {28'h0, stall_cnt}, {28'h0, s});
    chk({tag, "_flush"}, {28'h0, flush_cnt}, {28'h0, f});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    hz_stall = 2'b00;
    hz_pc_branch = 32'h0;
    imem_ready = 1'b1;
    dmem_busy = 1'b0;

    #2;
    chk("rst_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_BOOT});
    chk("rst_target", pc_target, 32'h0000_0100);
    chk_cnt("rst", 4'd0, 4'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_BOOT});
    chk("boot_target", pc_target, 32'h0000_0100);

    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("run0_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_NORM});
    chk_cnt("run0", 4'd0, 4'd0);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("run1_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_NORM});
    chk_cnt("run1", 4'd0, 4'd0);

    // Redirect with fetch ready.
    drive(2'b10, 32'h0000_0200, 1'b1, 1'b0);
    chk("redir_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_REDIR});
    chk("redir_target", pc_target, 32'h0000_0200);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("post_redir_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_NORM});
    chk_cnt("post_redir", 4'd0, 4'd1);

    // Redirect during a fetch miss, ready returning three cycles later.
    drive(2'b10, 32'h0000_0300, 1'b0, 1'b0);
    chk("rmiss_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_RMISS});
    chk("rmiss_target", pc_target, 32'h0000_0300);
    drive(2'b01, 32'h0000_0bad, 1'b0, 1'b0);
    chk("rwait0_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_WAIT});
    chk("rwait0_target", pc_target, 32'h0000_0300);
    chk_cnt("rwait0", 4'd1, 4'd2);
    drive(2'b10, 32'h0000_0bad, 1'b0, 1'b0);
    chk("rwait1_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_WAIT});
    chk_cnt("rwait1", 4'd2, 4'd2);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("rwait_done_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_WDONE});
    chk("rwait_done_target", pc_target, 32'h0000_0300);
    chk_cnt("rwait_done", 4'd3, 4'd2);

    // Load-use for two cycles, second one with a fetch miss too.
    drive(2'b01, 32'h0, 1'b1, 1'b0);
    chk("ldu0_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_LDUSE});
    chk_cnt("ldu0", 4'd3, 4'd2);
    drive(2'b01, 32'h0, 1'b0, 1'b0);
    chk("ldu1_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_LDUSE});
    chk_cnt("ldu1", 4'd4, 4'd2);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("post_ldu_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_NORM});
    chk_cnt("post_ldu", 4'd5, 4'd2);

    // Memory freeze with both hazards pending; redirect taken afterwards.
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 32'h0000_0400, 1'b1, 1'b1);
      chk("freeze_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_FREEZE});
      chk_cnt("freeze", 4'(5 + i), 4'd2);
    end
    drive(2'b11, 32'h0000_0400, 1'b1, 1'b0);
    chk("both_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_REDIR});
    chk("both_target", pc_target, 32'h0000_0400);
    chk_cnt("both", 4'd9, 4'd2);

    // Drive stall_cnt into saturation.
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 32'h0, 1'b1, 1'b0);
      chk_cnt("sat", (9 + i > 15) ? 4'hF : 4'(9 + i), 4'd3);
    end
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    chk("miss_ctrl", {21'h0, ctrl_vec()}, {21'h0, 11'b100_1111_1000});
    chk_cnt("sat_hold", 4'hF, 4'd3);

    // Asynchronous reset in the middle of RWAIT.
    drive(2'b10, 32'h0000_0500, 1'b0, 1'b0);
    chk_cnt("pre_rwait", 4'hF, 4'd3);
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    chk("rwait2_target", pc_target, 32'h0000_0500);
    chk_cnt("rwait2", 4'hF, 4'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_BOOT});
    chk("mid_rst_target", pc_target, 32'h0000_0100);
    chk_cnt("mid_rst", 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reboot_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_BOOT});
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("reboot_run_ctrl", {21'h0, ctrl_vec()}, {21'h0, C_NORM});
    chk_cnt("reboot_run", 4'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
